ss_mm_param: RTL and testbench

- Parametrised successor to the team's single-size streaming matrix block: accepts two square signed matrices A and B as a serial element stream and emits the product matrix serially, one element per out_valid pulse.
- Generalised to runtime-selectable size N ∈ {2,4,8}.
- Adds a mode input selecting C = A·B or C = Aᵀ·B.
- Sits behind the same in_valid/out_valid stream interface style as the existing matrix datapath blocks.

---
 rtl/ss_pkg.sv | 35 +++
 rtl/ss_mac.sv | 35 +++
 rtl/ss_mm_param.sv | 146 ++++++++++++++
 tb/tb_ss_mm_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and helpers for the serial matrix-multiply block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ss_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_MAX_N  = 8;

   localparam logic MODE_AB  = 1'b0;
   localparam logic MODE_ATB = 1'b1;

   // DONE is the single pulse cycle after the last MAC, in which new beats are ignored
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CALC,
      DONE
   } state_t;

   // size code -> log2(N); code 3 selects the largest supported dimension
   function automatic logic [3:0] size_lg(input logic [1:0] code, input logic [3:0] max_lg);
      case (code)
         2'd0:    return 4'd1;
         2'd1:    return 4'd2;
         2'd2:    return 4'd3;
         default: return max_lg;
      endcase
   endfunction

   // size code -> N
   function automatic int size_n(input logic [1:0] code, input logic [3:0] max_lg);
      return 1 << size_lg(code, max_lg);
   endfunction

endpackage

// File: rtl/ss_mac.sv
// Signed multiply-accumulate: acc = clr ? a*b : acc + a*b when en.
// Latency: 1 cycle from operands to registered accumulator.
// Backpressure: none; en gates the update.
module ss_mac #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 2*DATA_W+8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [OUT_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [OUT_W-1:0]    prod_ext;

   // full-precision product, sign-extended to accumulator width
   always_comb begin
      prod     = a * b;
      prod_ext = {{(OUT_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   // accumulator restarts with the first product of each element
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr ? prod_ext : acc + prod_ext;
      end
   end

endmodule

// File: rtl/ss_mm_param.sv
// Serial NxN signed matrix product (A*B or A^T*B), N in {2,4,8}, one MAC.
// Latency: last input beat at T -> element e pulses at T+(e+1)*N+1, idle again at T+N^3+2.
// Backpressure: none; a gap in in_valid during load aborts the job, beats during compute are ignored.
module ss_mm_param
   import ss_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MAX_N  = DEF_MAX_N,
   parameter int OUT_W  = 2*DATA_W+8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] matrix,
   input  logic [1:0]               matrix_size,
   input  logic                     in_mode,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_value
);

   localparam int LG_MAX = $clog2(MAX_N);
   localparam int IDX_W  = 2*LG_MAX;
   localparam int CNT_W  = IDX_W+1;

   state_t              state;
   logic [3:0]          n_lg;
   logic                mode;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    e_idx;
   logic [LG_MAX-1:0]   k_idx;

   logic [IDX_W-1:0]    n_m1;
   logic [IDX_W-1:0]    nsq_m1;
   logic [CNT_W-1:0]    load_last;
   logic [IDX_W-1:0]    kx, row_i, col_j, a_idx, b_idx;
   logic                k_last;

   logic                wr_en, wr_b;
   logic [IDX_W-1:0]    wr_addr;

   logic signed [DATA_W-1:0] a_buf [MAX_N*MAX_N];
   logic signed [DATA_W-1:0] b_buf [MAX_N*MAX_N];
   logic signed [OUT_W-1:0]  acc;

   // size-derived limits and operand addressing from the latched N
   always_comb begin
      n_m1      = IDX_W'((32'd1 << n_lg) - 32'd1);
      nsq_m1    = IDX_W'((32'd1 << (2*n_lg)) - 32'd1);
      load_last = CNT_W'((32'd1 << (2*n_lg+1)) - 32'd1);
      kx        = {{(IDX_W-LG_MAX){1'b0}}, k_idx};
      k_last    = (kx == n_m1);
      row_i     = e_idx >> n_lg;
      col_j     = e_idx & n_m1;
      a_idx     = (mode == MODE_ATB) ? ((kx << n_lg) | row_i) : ((row_i << n_lg) | kx);
      b_idx     = (kx << n_lg) | col_j;
   end

   // beat routing: first N^2 beats go to A, the rest to B (N^2 is a power of two)
   always_comb begin
      wr_en   = 1'b0;
      wr_b    = 1'b0;
      wr_addr = '0;
      if (in_valid && state == IDLE) begin
         wr_en = 1'b1;
      end else if (in_valid && state == LOAD) begin
         wr_en   = 1'b1;
         wr_b    = (cnt > {1'b0, nsq_m1});
         wr_addr = cnt[IDX_W-1:0] & nsq_m1;
      end
   end

   // operand storage; entries beyond the active N are never read
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_b) b_buf[wr_addr] <= matrix;
         else      a_buf[wr_addr] <= matrix;
      end
   end

   // control FSM: load counting, element/k sequencing, output pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_lg      <= 4'd1;
         mode      <= MODE_AB;
         cnt       <= '0;
         e_idx     <= '0;
         k_idx     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  n_lg  <= size_lg(matrix_size, 4'(LG_MAX));
                  mode  <= in_mode;
                  cnt   <= CNT_W'(1);
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (!in_valid) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == load_last) begin
                  cnt   <= '0;
                  e_idx <= '0;
                  k_idx <= '0;
                  state <= CALC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CALC: begin
               out_valid <= k_last;
               if (k_last) begin
                  k_idx <= '0;
                  if (e_idx == nsq_m1) state <= DONE;
                  else                 e_idx <= e_idx + 1'b1;
               end else begin
                  k_idx <= k_idx + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   ss_mac #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (k_idx == '0),
      .en    (state == CALC),
      .a     (a_buf[a_idx]),
      .b     (b_buf[b_idx]),
      .acc   (acc)
   );

   // accumulator still holds the finished sum during the pulse cycle
   assign out_value = out_valid ? acc : '0;

endmodule

// File: tb/tb_ss_mm_param.sv
// Directed bench for ss_mm_param: sizes 2/4/8, both modes, abort, async reset, ignored beats.
// Latency: checks exact pulse cycles relative to the final input beat.
// Backpressure: n/a.
module tb_ss_mm_param;

   localparam int DATA_W = 16;
   localparam int MAX_N  = 8;
   localparam int OUT_W  = 40;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_valid;
   logic signed [DATA_W-1:0] matrix;
   logic [1:0]               matrix_size;
   logic                     in_mode;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_value;

   ss_mm_param #(.DATA_W(DATA_W), .MAX_N(MAX_N), .OUT_W(OUT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .matrix      (matrix),
      .matrix_size (matrix_size),
      .in_mode     (in_mode),
      .out_valid   (out_valid),
      .out_value   (out_value)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     n_chk  = 0;
   int     n_pass = 0;
   int     t_fin  = 0;
   int     a_m [64];
   int     b_m [64];
   longint exp_v [64];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // drive nbeats consecutive beats; t_fin = cycle in which the last beat is presented
   task automatic send(input int code, input int mode, input int n, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         in_valid    = 1'b1;
         matrix_size = 2'(code);
         in_mode     = mode[0];
         matrix      = (b < n*n) ? DATA_W'(a_m[b]) : DATA_W'(b_m[b-n*n]);
         t_fin       = cyc;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      matrix   = '0;
   endtask

   // watch the whole compute window, checking value and cycle of every pulse;
   // returns one cycle after the last pulse, i.e. the earliest legal new first beat
   task automatic collect(input int n, input bit garbage);
      int np;
      int lim;
      np  = 0;
      lim = t_fin + n*n*n + 1;
      for (int c = t_fin + 1; c <= lim; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (np < 64) begin
               chk($sformatf("val_n%0d_e%0d", n, np), out_value, exp_v[np]);
               chk($sformatf("cyc_n%0d_e%0d", n, np), cyc - t_fin, (np+1)*n + 1);
            end
            np++;
         end
         if (garbage && c < lim) begin
            in_valid = 1'($urandom_range(0, 1));
            matrix   = DATA_W'($urandom);
         end else begin
            in_valid = 1'b0;
            matrix   = '0;
         end
      end
      chk($sformatf("npulse_n%0d", n), np, n*n);
      @(posedge clk);
      #1;
   endtask

   task automatic load_2x2(input int a0, a1, a2, a3, b0, b1, b2, b3, e0, e1, e2, e3);
      a_m[0] = a0; a_m[1] = a1; a_m[2] = a2; a_m[3] = a3;
      b_m[0] = b0; b_m[1] = b1; b_m[2] = b2; b_m[3] = b3;
      exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
   endtask

   initial begin
      int np;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      matrix      = '0;
      matrix_size = 2'd0;
      in_mode     = 1'b0;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_value", out_value, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // N=2, A=I, B=[1 2;3 4]
      load_2x2(1, 0, 0, 1,  1, 2, 3, 4,  1, 2, 3, 4);
      send(0, 0, 2, 8);
      collect(2, 1'b0);

      // N=2 transpose mode, A=[1 2;3 4], B=I -> A^T
      load_2x2(1, 2, 3, 4,  1, 0, 0, 1,  1, 3, 2, 4);
      send(0, 1, 2, 8);
      collect(2, 1'b0);

      // N=8 at most-negative values, via code 2 and code 3
      for (int i = 0; i < 64; i++) begin
         a_m[i]   = -32768;
         b_m[i]   = -32768;
         exp_v[i] = 64'sd8589934592;
      end
      send(2, 0, 8, 128);
      collect(8, 1'b0);
      send(3, 0, 8, 128);
      collect(8, 1'b0);

      // aborted load after 3 beats, then a full job
      load_2x2(1, 0, 0, 1,  5, -6, 7, 8,  5, -6, 7, 8);
      send(0, 0, 2, 3);
      np = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) np++;
      end
      chk("abort_pulses", np, 0);
      @(posedge clk);
      #1;
      send(0, 0, 2, 8);
      collect(2, 1'b0);

      // N=4, A=I, B=0..15; reset lands during the third pulse
      for (int i = 0; i < 16; i++) begin
         a_m[i]   = ((i % 4) == (i / 4)) ? 1 : 0;
         b_m[i]   = i;
         exp_v[i] = i;
      end
      send(1, 0, 4, 32);
      np = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (out_valid) np++;
         if (np == 3) break;
      end
      chk("mid_reach", np, 3);
      chk("mid_value", out_value, 2);
      rst_n = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_value", out_value, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1, 0, 4, 32);
      collect(4, 1'b0);

      // garbage beats during compute, then a back-to-back job at the earliest slot
      load_2x2(1, 2, 3, 4,  5, 6, 7, 8,  19, 22, 43, 50);
      send(0, 0, 2, 8);
      collect(2, 1'b1);
      load_2x2(1, 2, 3, 4,  5, 6, 7, 8,  26, 30, 38, 44);
      send(0, 1, 2, 8);
      collect(2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
